// File: rtl/blackbox_peer_if.sv
// blackbox_peer_if: request, response and box-facing signals of the box peer
interface blackbox_peer_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_data;
    logic [3:0] box_from;
    logic [3:0] box_to;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic [3:0] rsp_sent;
    logic       rsp_match;
    logic [7:0] tx_count;
    logic [7:0] err_count;
    modport slave (
        input  req_valid, req_data, rsp_ready, box_to,
        output req_ready, box_from, rsp_valid, rsp_data, rsp_sent, rsp_match, tx_count, err_count
    );
    modport master (
        output req_valid, req_data, rsp_ready, box_to,
        input  req_ready, box_from, rsp_valid, rsp_data, rsp_sent, rsp_match, tx_count, err_count
    );
endinterface

// File: rtl/blackbox_peer.sv
// blackbox_peer: drives one word into the box, inverts its transform and reports match/counters
module blackbox_peer #(
    parameter int MODE    = 0,
    parameter int LATENCY = 1
) (
    input logic           clk,
    input logic           rst,
    blackbox_peer_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    logic [1:0] state;
    logic [2:0] cnt;
    logic [3:0] dec;
    assign dec           = (MODE == 0) ? (bus.box_to ^ 4'hC) : (bus.box_to - 4'd1);
    assign bus.req_ready = rst && (state == IDLE);
    assign bus.rsp_valid = rst && (state == RESP);
    // single-transaction sequencer: launch word, wait out box latency, hold response until taken
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.box_from  <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_sent  <= '0;
            bus.rsp_match <= 1'b0;
            bus.tx_count  <= '0;
            bus.err_count <= '0;
        end else if (state == IDLE) begin
            if (bus.req_valid) begin
                bus.box_from <= bus.req_data;
                bus.rsp_sent <= bus.req_data;
                cnt          <= 3'(LATENCY);
                state        <= WAIT;
            end
        end else if (state == WAIT) begin
            if (cnt == 3'd0) begin
                bus.rsp_data  <= dec;
                bus.rsp_match <= (dec == bus.rsp_sent);
                state         <= RESP;
            end else begin
                cnt <= cnt - 3'd1;
            end
        end else if (state == RESP) begin
            if (bus.rsp_ready) begin
                bus.tx_count  <= bus.tx_count + 8'd1;
                bus.err_count <= bus.err_count + {7'd0, !bus.rsp_match && (bus.err_count != 8'hFF)};
                state         <= IDLE;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_blackbox_peer.sv
// tb_blackbox_peer: directed checks of three peers against XOR and increment box models
module tb_blackbox_peer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    logic fe = 1'b0;
    logic [3:0] fv = 4'h0;
    logic [3:0] p0, p1;
    logic [2:0][3:0] q2;
    logic [2:0] rv = '0;
    logic [2:0] rr = '0;
    logic [2:0][3:0] rd = '0;
    logic [2:0] qr, vl, mt;
    logic [2:0][3:0] bf, od, os, bt;
    logic [2:0][7:0] tc, ec;
    blackbox_peer_if b0 ();
    blackbox_peer_if b1 ();
    blackbox_peer_if b2 ();
    blackbox_peer #(.MODE(0), .LATENCY(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
    blackbox_peer #(.MODE(1), .LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    blackbox_peer #(.MODE(1), .LATENCY(3)) u2 (.clk(clk), .rst(rst), .bus(b2));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        p0    <= b0.box_from ^ 4'hC;
        p1    <= b1.box_from + 4'd1;
        q2[0] <= b2.box_from + 4'd1;
        q2[1] <= q2[0];
        q2[2] <= q2[1];
    end
    assign b0.box_to = fe ? fv : p0;
    assign b1.box_to = p1;
    assign b2.box_to = q2[2];
    assign b0.req_valid = rv[0];
    assign b1.req_valid = rv[1];
    assign b2.req_valid = rv[2];
    assign b0.req_data = rd[0];
    assign b1.req_data = rd[1];
    assign b2.req_data = rd[2];
    assign b0.rsp_ready = rr[0];
    assign b1.rsp_ready = rr[1];
    assign b2.rsp_ready = rr[2];
    assign qr = {b2.req_ready, b1.req_ready, b0.req_ready};
    assign vl = {b2.rsp_valid, b1.rsp_valid, b0.rsp_valid};
    assign mt = {b2.rsp_match, b1.rsp_match, b0.rsp_match};
    assign bf = {b2.box_from, b1.box_from, b0.box_from};
    assign od = {b2.rsp_data, b1.rsp_data, b0.rsp_data};
    assign os = {b2.rsp_sent, b1.rsp_sent, b0.rsp_sent};
    assign bt = {b2.box_to, b1.box_to, b0.box_to};
    assign tc = {b2.tx_count, b1.tx_count, b0.tx_count};
    assign ec = {b2.err_count, b1.err_count, b0.err_count};

    task automatic send(input int s, input logic [3:0] d, output int w, output int lat, output logic [3:0] fb);
        w = 0;
        while (!qr[s] && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!qr[s]) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout dut=%0d got=0 want=1", s);
        end
        rv[s] = 1'b1;
        rd[s] = d;
        @(negedge clk);
        rv[s] = 1'b0;
        fb = bf[s];
        lat = 0;
        while (!vl[s] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!vl[s]) begin
            checks++;
            failures++;
            $display("FAIL valid_timeout dut=%0d got=0 want=1", s);
        end
    endtask

    task automatic ack(input int s);
        rr[s] = 1'b1;
        @(negedge clk);
        rr[s] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (qr[0] !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%0b want=0", qr[0]); end
        checks++; if (vl[0] !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%0b want=0", vl[0]); end
        checks++; if (bf[0] !== 4'h0) begin failures++; $display("FAIL rst_box_from got=%0h want=0", bf[0]); end
        checks++; if (od[0] !== 4'h0 || mt[0] !== 1'b0) begin failures++; $display("FAIL rst_rsp got=%0h/%0b want=0/0", od[0], mt[0]); end
        checks++; if (tc[0] !== 8'd0 || ec[0] !== 8'd0) begin failures++; $display("FAIL rst_counts got=%0d/%0d want=0/0", tc[0], ec[0]); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (qr !== 3'b111) begin failures++; $display("FAIL release_ready got=%b want=111", qr); end
    endtask

    task automatic test_mode0;
        int w, lat;
        logic [3:0] fb;
        send(0, 4'h5, w, lat, fb);
        checks++; if (fb !== 4'h5) begin failures++; $display("FAIL m0_box_from got=%0h want=5", fb); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL m0_latency got=%0d want=2", lat); end
        checks++; if (bt[0] !== 4'h9) begin failures++; $display("FAIL m0_box_to got=%0h want=9", bt[0]); end
        checks++; if (od[0] !== 4'h5 || mt[0] !== 1'b1) begin failures++; $display("FAIL m0_rsp got=%0h/%0b want=5/1", od[0], mt[0]); end
        checks++; if (qr[0] !== 1'b0) begin failures++; $display("FAIL m0_no_bypass got=%0b want=0", qr[0]); end
        ack(0);
        checks++; if (tc[0] !== 8'd1 || ec[0] !== 8'd0) begin failures++; $display("FAIL m0_counts got=%0d/%0d want=1/0", tc[0], ec[0]); end
        checks++; if (qr[0] !== 1'b1 || vl[0] !== 1'b0) begin failures++; $display("FAIL m0_idle got=%0b/%0b want=1/0", qr[0], vl[0]); end
    endtask

    task automatic test_mode1;
        int w, lat;
        logic [3:0] fb;
        send(1, 4'hF, w, lat, fb);
        checks++; if (bt[1] !== 4'h0) begin failures++; $display("FAIL m1_box_to got=%0h want=0", bt[1]); end
        checks++; if (od[1] !== 4'hF || mt[1] !== 1'b1) begin failures++; $display("FAIL m1_wrap got=%0h/%0b want=f/1", od[1], mt[1]); end
        ack(1);
        send(1, 4'h0, w, lat, fb);
        checks++; if (od[1] !== 4'h0 || mt[1] !== 1'b1) begin failures++; $display("FAIL m1_zero got=%0h/%0b want=0/1", od[1], mt[1]); end
        ack(1);
        checks++; if (tc[1] !== 8'd2 || ec[1] !== 8'd0) begin failures++; $display("FAIL m1_counts got=%0d/%0d want=2/0", tc[1], ec[1]); end
    endtask

    task automatic test_mismatch;
        int w, lat;
        logic [3:0] fb;
        fe = 1'b1;
        fv = 4'h3;
        send(0, 4'hA, w, lat, fb);
        checks++; if (od[0] !== 4'hF || mt[0] !== 1'b0) begin failures++; $display("FAIL mm_rsp got=%0h/%0b want=f/0", od[0], mt[0]); end
        checks++; if (os[0] !== 4'hA) begin failures++; $display("FAIL mm_sent got=%0h want=a", os[0]); end
        checks++; if (ec[0] !== 8'd0) begin failures++; $display("FAIL mm_err_pre got=%0d want=0", ec[0]); end
        ack(0);
        checks++; if (ec[0] !== 8'd1 || tc[0] !== 8'd2) begin failures++; $display("FAIL mm_counts got=%0d/%0d want=1/2", ec[0], tc[0]); end
        fe = 1'b0;
    endtask

    task automatic test_hold;
        int w, lat;
        logic [3:0] fb;
        send(0, 4'h6, w, lat, fb);
        rv[0] = 1'b1;
        rd[0] = 4'h9;
        repeat (3) begin
            @(negedge clk);
            checks++; if (vl[0] !== 1'b1 || od[0] !== 4'h6) begin failures++; $display("FAIL hold_rsp got=%0b/%0h want=1/6", vl[0], od[0]); end
            checks++; if (qr[0] !== 1'b0 || tc[0] !== 8'd2) begin failures++; $display("FAIL hold_state got=%0b/%0d want=0/2", qr[0], tc[0]); end
        end
        rv[0] = 1'b0;
        ack(0);
        checks++; if (tc[0] !== 8'd3) begin failures++; $display("FAIL hold_tx got=%0d want=3", tc[0]); end
        repeat (2) @(negedge clk);
        checks++; if (bf[0] !== 4'h6) begin failures++; $display("FAIL hold_box_from got=%0h want=6", bf[0]); end
    endtask

    task automatic test_reset_mid;
        int seen;
        rd[0] = 4'h7;
        rv[0] = 1'b1;
        @(negedge clk);
        rv[0] = 1'b0;
        checks++; if (bf[0] !== 4'h7 || qr[0] !== 1'b0) begin failures++; $display("FAIL mid_accept got=%0h/%0b want=7/0", bf[0], qr[0]); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (vl[0] !== 1'b0 || bf[0] !== 4'h0) begin failures++; $display("FAIL mid_rst got=%0b/%0h want=0/0", vl[0], bf[0]); end
        checks++; if (tc[0] !== 8'd0 || ec[0] !== 8'd0) begin failures++; $display("FAIL mid_counts got=%0d/%0d want=0/0", tc[0], ec[0]); end
        rst = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (vl[0]) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL mid_no_rsp got=%0d want=0", seen); end
        checks++; if (qr[0] !== 1'b1) begin failures++; $display("FAIL mid_idle got=%0b want=1", qr[0]); end
    endtask

    task automatic test_saturate;
        int w, lat;
        logic [3:0] fb;
        fe = 1'b1;
        fv = 4'h3;
        for (int i = 0; i < 300; i++) begin
            send(0, 4'h0, w, lat, fb);
            ack(0);
            if (i == 255) begin
                checks++; if (tc[0] !== 8'd0 || ec[0] !== 8'd255) begin failures++; $display("FAIL sat_256 got=%0d/%0d want=0/255", tc[0], ec[0]); end
            end
        end
        checks++; if (ec[0] !== 8'd255) begin failures++; $display("FAIL sat_err got=%0d want=255", ec[0]); end
        checks++; if (tc[0] !== 8'd44) begin failures++; $display("FAIL sat_tx got=%0d want=44", tc[0]); end
        fe = 1'b0;
    endtask

    task automatic test_back_to_back;
        int w, lat;
        logic [3:0] fb;
        logic [3:0] d;
        for (int i = 0; i < 16; i++) begin
            d = 4'(i);
            send(2, d, w, lat, fb);
            checks++; if (w !== 0) begin failures++; $display("FAIL b2b_wait i=%0d got=%0d want=0", i, w); end
            checks++; if (lat !== 4) begin failures++; $display("FAIL b2b_latency i=%0d got=%0d want=4", i, lat); end
            checks++; if (od[2] !== d || mt[2] !== 1'b1) begin failures++; $display("FAIL b2b_rsp i=%0d got=%0h/%0b want=%0h/1", i, od[2], mt[2], d); end
            ack(2);
        end
        checks++; if (tc[2] !== 8'd16 || ec[2] !== 8'd0) begin failures++; $display("FAIL b2b_counts got=%0d/%0d want=16/0", tc[2], ec[2]); end
    endtask

    initial begin
        test_reset;
        test_mode0;
        test_mode1;
        test_mismatch;
        test_hold;
        test_reset_mid;
        test_saturate;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
